// File: rtl/bd_shift_feeder.sv
// bd_shift_feeder: serializes parallel words into the dr/dl/mode inputs of a
// WIDTH-deep bidirectional shift register, one bit per clock, and pulses
// word_ok in the cycle the register's q holds the completed word.
// Optional feature macro: BD_FEED_ABORT_EN adds an 'abort' input that cancels
// the word in flight.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_valid may rise or fall freely while in_ready is 0; nothing is taken
// until both are high. in_ready is combinational from state and reset only
// (plus abort when enabled), never from in_valid.
module bd_shift_feeder #(
    parameter int   WIDTH = 4,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_valid,
`ifdef BD_FEED_ABORT_EN
    input  logic             abort,
`endif
    output logic             in_ready,
    output logic             dr,
    output logic             dl,
    output logic             mode,
    output logic             busy,
    output logic             word_ok
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_buf_q, sh_buf_d;
    logic             dr_d, dl_d, mode_d, busy_d, ok_d;
    logic             abort_w;
    logic             last_bit;
    logic             accept;
    logic             do_load;

`ifdef BD_FEED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // The cycle presenting the final bit is the only SHIFT cycle that can accept.
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign in_ready = rst && !((state_q == SHIFT) && abort_w)
                      && ((state_q == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;

    // Next-state and registered-output values; serial lines default to FILL.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_buf_d = sh_buf_q;
        dr_d     = FILL;
        dl_d     = FILL;
        mode_d   = mode_q_w();
        busy_d   = busy;
        ok_d     = 1'b0;
        do_load  = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (accept) do_load = 1'b1;
            end
            SHIFT: begin
                if (abort_w) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (last_bit) begin
                    // Last bit lands in the register at this edge.
                    ok_d = 1'b1;
                    if (accept) begin
                        do_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Buffer already has the presented bits shifted out.
                    if (mode) begin
                        dr_d     = sh_buf_q[0];
                        sh_buf_d = sh_buf_q >> 1;
                    end else begin
                        dl_d     = sh_buf_q[WIDTH-1];
                        sh_buf_d = sh_buf_q << 1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Present bit 0 of the new word now; keep the rest for later cycles.
        if (do_load) begin
            state_d = SHIFT;
            cnt_d   = '0;
            busy_d  = 1'b1;
            mode_d  = in_dir;
            if (in_dir) begin
                dr_d     = in_data[0];
                sh_buf_d = in_data >> 1;
            end else begin
                dl_d     = in_data[WIDTH-1];
                sh_buf_d = in_data << 1;
            end
        end
    end

    // Current direction, held across idle periods.
    function automatic logic mode_q_w();
        return mode;
    endfunction

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_buf_q <= '0;
            dr       <= FILL;
            dl       <= FILL;
            mode     <= 1'b0;
            busy     <= 1'b0;
            word_ok  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_buf_q <= sh_buf_d;
            dr       <= dr_d;
            dl       <= dl_d;
            mode     <= mode_d;
            busy     <= busy_d;
            word_ok  <= ok_d;
        end
    end

endmodule
